// File: rtl/hsi_vector_tx_if.sv
`default_nettype none
// ============================================================================
// hsi_vector_tx_if : control, element-source and FIFO-push bundle for hsi_vector_tx
// Rev 1.0 ; words_sent_out present only when HSI_VECTOR_TX_CNT_EN is defined
// ============================================================================
interface hsi_vector_tx_if #(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] vectors_in;
  logic                  elem_valid;
  logic [DATA_WIDTH-1:0] elem_data;
  logic                  elem_ready;
  logic                  word_out_en;
  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_out_full;
  logic                  done;
  logic                  idle;
  logic                  ready;
`ifdef HSI_VECTOR_TX_CNT_EN
  logic [31:0]           words_sent_out;

  modport master (
    output start, vectors_in, elem_valid, elem_data, word_out_full,
    input  elem_ready, word_out_en, word_out, done, idle, ready, words_sent_out
  );
  modport slave (
    input  start, vectors_in, elem_valid, elem_data, word_out_full,
    output elem_ready, word_out_en, word_out, done, idle, ready, words_sent_out
  );
`else
  modport master (
    output start, vectors_in, elem_valid, elem_data, word_out_full,
    input  elem_ready, word_out_en, word_out, done, idle, ready
  );
  modport slave (
    input  start, vectors_in, elem_valid, elem_data, word_out_full,
    output elem_ready, word_out_en, word_out, done, idle, ready
  );
`endif
endinterface
`default_nettype wire

// File: rtl/hsi_vector_tx.sv
`default_nettype none
// ============================================================================
// hsi_vector_tx : packs HSI band elements into FIFO words, vector by vector
// Rev 1.0 ; optional push counter enabled by macro HSI_VECTOR_TX_CNT_EN
// ============================================================================
module hsi_vector_tx #(
  parameter int WORD_WIDTH            = 32,
  parameter int DATA_WIDTH            = 16,
  parameter int HSI_BANDS             = 128,
  parameter int HSI_LIBRARY_SIZE      = 256,
  parameter int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic           clk,
  input  logic           rst_n,
  hsi_vector_tx_if.slave bus
);
  localparam int PACK   = WORD_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int BAND_W = (HSI_BANDS > 1) ? $clog2(HSI_BANDS) : 1;
  localparam int VEC_W  = HSI_LIBRARY_SIZE_ADDR;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
  localparam logic [BAND_W-1:0] LAST_ELEM = BAND_W'(HSI_BANDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state;
  logic                    done_q;
  logic                    idle_q;
  logic                    ready_q;
  logic [LANE_W-1:0]       lane_cnt;
  logic [BAND_W-1:0]       elem_cnt;
  logic [VEC_W-1:0]        vec_cnt;
  logic [VEC_W-1:0]        vec_last;
  logic [WORD_WIDTH-1:0]   asm_word;
  logic [WORD_WIDTH-1:0]   asm_next;
  logic [WORD_WIDTH-1:0]   hold_word;
  logic                    hold_valid;

  logic last_elem;
  logic last_vec;
  logic word_complete;
  logic push;
  logic elem_ready;
  logic accept;
  logic start_ok;

  assign last_elem     = (elem_cnt == LAST_ELEM);
  assign last_vec      = (vec_cnt == vec_last);
  assign word_complete = (lane_cnt == LAST_LANE) || last_elem;
  assign push          = hold_valid && !bus.word_out_full;
  // A word may complete while the holding register drains in the same cycle.
  assign elem_ready    = (state == S_STREAM) &&
                         !(word_complete && hold_valid && bus.word_out_full);
  assign accept        = bus.elem_valid && elem_ready;
  assign start_ok      = (state == S_IDLE) && bus.start;

  always_comb begin
    asm_next = asm_word;
    for (int k = 0; k < PACK; k++) begin
      if (lane_cnt == LANE_W'(k)) begin
        asm_next[k*DATA_WIDTH +: DATA_WIDTH] = bus.elem_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            idle_q  <= 1'b0;
            ready_q <= 1'b0;
            if (bus.vectors_in != '0) begin
              state <= S_STREAM;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (accept && last_elem && last_vec) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!hold_valid || push) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt   <= '0;
      elem_cnt   <= '0;
      vec_cnt    <= '0;
      vec_last   <= '0;
      asm_word   <= '0;
      hold_word  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        lane_cnt <= '0;
        elem_cnt <= '0;
        vec_cnt  <= '0;
        vec_last <= bus.vectors_in - VEC_W'(1);
        asm_word <= '0;
      end else if (accept) begin
        // Clearing the assembly word keeps unused upper lanes zero at a vector end.
        if (word_complete) begin
          asm_word <= '0;
          lane_cnt <= '0;
        end else begin
          asm_word <= asm_next;
          lane_cnt <= lane_cnt + LANE_W'(1);
        end
        if (last_elem) begin
          elem_cnt <= '0;
          vec_cnt  <= vec_cnt + VEC_W'(1);
        end else begin
          elem_cnt <= elem_cnt + BAND_W'(1);
        end
      end

      if (accept && word_complete) begin
        hold_word  <= asm_next;
        hold_valid <= 1'b1;
      end else if (push) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef HSI_VECTOR_TX_CNT_EN
  logic [31:0] words_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent <= '0;
    end else if (start_ok) begin
      words_sent <= '0;
    end else if (push) begin
      words_sent <= words_sent + 32'd1;
    end
  end

  assign bus.words_sent_out = words_sent;
`endif

  assign bus.elem_ready  = elem_ready;
  assign bus.word_out_en = push;
  assign bus.word_out    = hold_word;
  assign bus.done        = done_q;
  assign bus.idle        = idle_q;
  assign bus.ready       = ready_q;

endmodule
`default_nettype wire
